// File: rtl/prog_dumper.sv
// prog_dumper: program-memory readback engine.
// On a start request it reads ROM words 0..WORDS-1 and sends each one over a UART TX line as
// two 8N1 bytes, high byte first. The byte order and framing match the UART program loader.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   start  in   level-sampled dump request, acted on only while idle
//   DIN    in   ROM read data (16 bits)
//   RADD   out  ROM read address
//   rden   out  ROM read enable, one-cycle pulse per word
//   tx     out  UART serial output, idle high
//   busy   out  high whenever the engine is not idle
//   done   out  one-cycle pulse after the last word's stop bit
module prog_dumper #(
  parameter int unsigned INCLOCK       = 50000000,
  parameter int unsigned BAUDE         = 115200,
  parameter int unsigned ROM_ADD_WIDTH = 11,
  parameter int unsigned WORDS         = 2 ** (ROM_ADD_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            DIN,
  output logic [ROM_ADD_WIDTH:0] RADD,
  output logic                   rden,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned UBRR = INCLOCK / BAUDE;
  localparam int unsigned AW   = ROM_ADD_WIDTH + 1;

  localparam logic [14:0]   ClkLast  = 15'(UBRR - 1);
  localparam logic [AW-1:0] AddrLast = AW'(WORDS - 1);
  localparam logic [3:0]    BitStop  = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StLatch,
    StTxHi,
    StTxLo,
    StNext,
    StDone
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_radd, w_radd_nxt;
  logic [15:0]   r_word, w_word_nxt;
  logic [3:0]    r_bit, w_bit_nxt;    // 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  logic [14:0]   r_clk, w_clk_nxt;    // clocks elapsed within the current bit

  logic          w_bit_end;
  logic [7:0]    w_byte;
  logic [2:0]    w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_radd  <= '0;
      r_word  <= '0;
      r_bit   <= '0;
      r_clk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_radd  <= w_radd_nxt;
      r_word  <= w_word_nxt;
      r_bit   <= w_bit_nxt;
      r_clk   <= w_clk_nxt;
    end
  end

  assign w_bit_end = (r_clk == ClkLast);

  always_comb begin
    w_state_nxt = r_state;
    w_radd_nxt  = r_radd;
    w_word_nxt  = r_word;
    w_bit_nxt   = r_bit;
    w_clk_nxt   = r_clk;
    case (r_state)
      StIdle: begin
        w_radd_nxt = '0;
        if (start) w_state_nxt = StRead;
      end
      StRead:  w_state_nxt = StWait;
      StWait:  w_state_nxt = StLatch;
      StLatch: begin
        // RADD has been stable since READ, so a registered-address ROM is valid here.
        w_word_nxt  = DIN;
        w_state_nxt = StTxHi;
      end
      StTxHi, StTxLo: begin
        if (w_bit_end) begin
          w_clk_nxt = '0;
          if (r_bit == BitStop) begin
            // Next byte (or NEXT) starts on the very next edge: no inter-byte gap.
            w_bit_nxt   = '0;
            w_state_nxt = (r_state == StTxHi) ? StTxLo : StNext;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else begin
          w_clk_nxt = r_clk + 15'd1;
        end
      end
      StNext: begin
        if (r_radd == AddrLast) begin
          w_radd_nxt  = '0;
          w_state_nxt = StDone;
        end else begin
          w_radd_nxt  = r_radd + 1'b1;
          w_state_nxt = StRead;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_byte = (r_state == StTxHi) ? r_word[15:8] : r_word[7:0];
  assign w_idx  = 3'(r_bit - 4'd1);

  // Line level decoded from registered state, so a reset edge forces the line high at once.
  always_comb begin
    tx = 1'b1;
    if (r_state == StTxHi || r_state == StTxLo) begin
      if (r_bit == 4'd0) begin
        tx = 1'b0;
      end else if (r_bit == BitStop) begin
        tx = 1'b1;
      end else begin
        tx = w_byte[w_idx];
      end
    end
  end

  assign RADD = r_radd;
  assign rden = (r_state == StRead);
  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);

endmodule

// File: tb/tb_prog_dumper.sv
// tb_prog_dumper: scoreboard bench for prog_dumper (ubrr = 4, WORDS = 4, 4-bit address).
// Stimulus pushes the expected ROM reads, UART frames (byte + first low sample cycle) and done
// pulse into queues; independent monitors pop and compare whenever the DUT presents them.
module tb_prog_dumper;

  localparam int unsigned INCLOCK  = 8;
  localparam int unsigned BAUDE    = 2;
  localparam int unsigned UBRR     = INCLOCK / BAUDE;
  localparam int unsigned RAW      = 3;
  localparam int unsigned AW       = RAW + 1;
  localparam int unsigned WORDS    = 4;
  localparam int unsigned WORD_CYC = 20 * UBRR + 4;
  localparam int unsigned FRAME    = 10 * UBRR;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   din;
  logic [AW-1:0] radd;
  logic          rden;
  logic          tx;
  logic          busy;
  logic          done;

  prog_dumper #(
    .INCLOCK      (INCLOCK),
    .BAUDE        (BAUDE),
    .ROM_ADD_WIDTH(RAW),
    .WORDS        (WORDS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .DIN  (din),
    .RADD (radd),
    .rden (rden),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-address synchronous ROM.
  logic [15:0] rom [WORDS];
  always @(posedge clk) din <= rom[radd[1:0]];

  typedef struct {
    int unsigned val;
    int unsigned t;
  } exp_t;

  exp_t        q_addr [$];
  exp_t        q_frame[$];
  int unsigned q_done [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: timing straight from the per-word and per-frame arithmetic.
  task automatic push_dump(input int unsigned e0);
    for (int w = 0; w < int'(WORDS); w++) begin
      int unsigned base;
      base = e0 + w * WORD_CYC;
      q_addr.push_back('{val: w, t: base});
      q_frame.push_back('{val: int'(rom[w] >> 8), t: base + 3});
      q_frame.push_back('{val: int'(rom[w] & 16'hff), t: base + 3 + FRAME});
    end
    q_done.push_back(e0 + WORDS * WORD_CYC);
  endtask

  // ROM read monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && rden === 1'b1) begin
      if (q_addr.size() == 0) begin
        unexpected("rden");
      end else begin
        exp_t e;
        e = q_addr.pop_front();
        chk("rden_addr", 32'(radd), e.val);
        chk("rden_time", cyc, e.t);
      end
    end
  end

  // Done pulse monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (q_done.size() == 0) begin
        unexpected("done");
      end else begin
        chk("done_time", cyc, q_done.pop_front());
      end
    end
  end

  // UART decoder: 40 samples per frame, one per clock; a reset abandons the frame.
  logic s [FRAME];
  initial begin : uart_mon
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        int unsigned t0;
        bit          aborted;
        int          shape_err;
        logic [7:0]  data;
        logic        ref_lvl;
        exp_t        e;
        t0      = cyc;
        aborted = 1'b0;
        s[0]    = 1'b0;
        for (int i = 1; i < int'(FRAME); i++) begin
          @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          s[i] = tx;
        end
        if (!aborted) begin
          shape_err = 0;
          for (int k = 0; k < 8; k++) data[k] = s[(k + 1) * UBRR];
          for (int b = 0; b < 10; b++) begin
            ref_lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b - 1];
            for (int j = 0; j < int'(UBRR); j++) begin
              if (s[b * UBRR + j] !== ref_lvl) shape_err++;
            end
          end
          if (q_frame.size() == 0) begin
            unexpected("uart_frame");
          end else begin
            e = q_frame.pop_front();
            chk("uart_byte", 32'(data), e.val);
            chk("uart_time", t0, e.t);
            chk("uart_shape", shape_err, 0);
          end
        end
      end
    end
  end

  task automatic begin_dump(input bit hold, output int unsigned e0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    if (!hold) start = 1'b0;
    push_dump(e0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: busy still %b after 3000 cycles, required 0", busy);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx"}, 32'(tx), 1);
    chk({tag, "_radd"}, 32'(radd), 0);
    chk({tag, "_rden"}, 32'(rden), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < int'(WORDS); i++) rom[i] = 16'($urandom);
  endtask

  initial begin : stim
    int unsigned e0;
    int          bad;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) rom[i] = 16'hA55A;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then quiet while start stays low.
    @(negedge clk);
    check_reset_outputs("reset");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rden !== 1'b0 || done !== 1'b0 || radd !== '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Fixed 16'hA55A words, then the {10+a, 20+a} pattern.
    begin_dump(1'b0, e0);
    wait_idle();
    for (int a = 0; a < int'(WORDS); a++) rom[a] = {8'(8'h10 + a), 8'(8'h20 + a)};
    begin_dump(1'b0, e0);
    wait_idle();
    chk("radd_after_dump", 32'(radd), 0);

    // Random images.
    for (int r = 0; r < 3; r++) begin
      randomize_rom();
      begin_dump(1'b0, e0);
      wait_idle();
    end

    // start pulsed during the second word is ignored.
    randomize_rom();
    begin_dump(1'b0, e0);
    wait_until(e0 + WORD_CYC + 10);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset during data bit 3 of the high byte, then a fresh dump from address 0.
    randomize_rom();
    begin_dump(1'b0, e0);
    wait_until(e0 + 3 + 4 * UBRR + 1);
    rst = 1'b1;
    q_addr.delete();
    q_frame.delete();
    q_done.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    randomize_rom();
    begin_dump(1'b0, e0);
    wait_idle();

    // start held high: second dump begins right after DONE.
    randomize_rom();
    begin_dump(1'b1, e0);
    push_dump(e0 + WORDS * WORD_CYC + 2);
    wait_until(e0 + WORDS * WORD_CYC + 2 + 5);
    start = 1'b0;
    wait_idle();

    repeat (20) @(negedge clk);
    chk("q_addr_left", q_addr.size(), 0);
    chk("q_frame_left", q_frame.size(), 0);
    chk("q_done_left", q_done.size(), 0);
    chk("final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
